// File: rtl/alu_issue_if.sv
// Request, ALU-drive and response signals that connect the shared-ALU issue arbiter
// to its two requesters, the ALU and the response consumer.
interface alu_issue_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  req0_valid;
   logic                  req0_ready;
   logic [2:0]            req0_aluop;
   logic [4:0]            req0_func;
   logic [DATA_WIDTH-1:0] req0_a;
   logic [DATA_WIDTH-1:0] req0_b;

   logic                  req1_valid;
   logic                  req1_ready;
   logic [2:0]            req1_aluop;
   logic [4:0]            req1_func;
   logic [DATA_WIDTH-1:0] req1_a;
   logic [DATA_WIDTH-1:0] req1_b;

   logic                  alu_start;
   logic [2:0]            alu_op;
   logic [4:0]            alu_func;
   logic [DATA_WIDTH-1:0] alu_a;
   logic [DATA_WIDTH-1:0] alu_b;
   logic [DATA_WIDTH-1:0] alu_result;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_id;
   logic [DATA_WIDTH-1:0] rsp_result;

   modport slave (
      input  req0_valid, req0_aluop, req0_func, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_aluop, req1_func, req1_a, req1_b,
      output req1_ready,
      output alu_start, alu_op, alu_func, alu_a, alu_b,
      input  alu_result,
      output rsp_valid, rsp_id, rsp_result,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_aluop, req0_func, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_aluop, req1_func, req1_a, req1_b,
      input  req1_ready,
      input  alu_start, alu_op, alu_func, alu_a, alu_b,
      output alu_result,
      input  rsp_valid, rsp_id, rsp_result,
      output rsp_ready
   );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin sharing of the execute-stage ALU between the integer pipeline (id 0)
// and the address/branch-target helper (id 1); one operation in flight at a time.
module alu_issue_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int ALU_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_issue_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q;
   logic                  last_q;
   logic                  grant_id;
   logic                  ready0, ready1, accept;
   logic                  start_q;
   logic [2:0]            iss_op_q;
   logic [4:0]            iss_func_q;
   logic [DATA_WIDTH-1:0] iss_a_q, iss_b_q;
   logic                  rsp_id_q;
   logic [DATA_WIDTH-1:0] rsp_result_q;

   // Grant: a lone requester wins; on a tie, whoever was not granted last.
   always_comb begin
      grant_id = 1'b0;
      if (bus.req0_valid && bus.req1_valid)
         grant_id = ~last_q;
      else if (bus.req1_valid)
         grant_id = 1'b1;
   end

   assign ready0 = (state_q == IDLE) && bus.req0_valid && !grant_id;
   assign ready1 = (state_q == IDLE) && bus.req1_valid && grant_id;
   assign accept = ready0 || ready1;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    if (cnt_q == 4'd1) state_d = RESP;
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_q       <= 1'b1;
         start_q      <= 1'b0;
         iss_op_q     <= '0;
         iss_func_q   <= '0;
         iss_a_q      <= '0;
         iss_b_q      <= '0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
      end else begin
         state_q <= state_d;
         start_q <= accept;
         if (accept) begin
            iss_op_q   <= grant_id ? bus.req1_aluop : bus.req0_aluop;
            iss_func_q <= grant_id ? bus.req1_func  : bus.req0_func;
            iss_a_q    <= grant_id ? bus.req1_a     : bus.req0_a;
            iss_b_q    <= grant_id ? bus.req1_b     : bus.req0_b;
            rsp_id_q   <= grant_id;
            last_q     <= grant_id;
            cnt_q      <= 4'(ALU_LATENCY);
         end else if (state_q == EXEC) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1)
               rsp_result_q <= bus.alu_result;
         end
      end
   end

   // ALU sees the issued operation only while executing; NOP otherwise.
   assign bus.alu_start  = start_q;
   assign bus.alu_op     = (state_q == EXEC) ? iss_op_q   : 3'b000;
   assign bus.alu_func   = (state_q == EXEC) ? iss_func_q : 5'b00000;
   assign bus.alu_a      = (state_q == EXEC) ? iss_a_q    : '0;
   assign bus.alu_b      = (state_q == EXEC) ? iss_b_q    : '0;

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;

   assign bus.rsp_valid  = (state_q == RESP);
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: a latency-1 instance with an adding ALU and
// a response scoreboard, plus a latency-3 instance driven with per-cycle ALU results.
module tb_alu_issue_arbiter;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   logic [32:0] sb[$];

   alu_issue_if #(.DATA_WIDTH(32)) bus1 ();
   alu_issue_if #(.DATA_WIDTH(32)) bus3 ();

   alu_issue_arbiter #(.DATA_WIDTH(32), .ALU_LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1)
   );
   alu_issue_arbiter #(.DATA_WIDTH(32), .ALU_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3)
   );

   assign bus1.alu_result = bus1.alu_a + bus1.alu_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Response scoreboard for the latency-1 instance; handshake sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n && bus1.rsp_valid && bus1.rsp_ready) begin
         chk("rsp_pending", 64'(sb.size() > 0), 64'd1);
         if (sb.size() > 0) begin
            logic [32:0] e;
            e = sb.pop_front();
            chk("rsp_id", 64'(bus1.rsp_id), 64'(e[32]));
            chk("rsp_result", 64'(bus1.rsp_result), 64'(e[31:0]));
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      bus1.req0_valid = 0; bus1.req0_aluop = 0; bus1.req0_func = 0; bus1.req0_a = 0; bus1.req0_b = 0;
      bus1.req1_valid = 0; bus1.req1_aluop = 0; bus1.req1_func = 0; bus1.req1_a = 0; bus1.req1_b = 0;
      bus1.rsp_ready = 0;
      bus3.req0_valid = 0; bus3.req0_aluop = 0; bus3.req0_func = 0; bus3.req0_a = 0; bus3.req0_b = 0;
      bus3.req1_valid = 0; bus3.req1_aluop = 0; bus3.req1_func = 0; bus3.req1_a = 0; bus3.req1_b = 0;
      bus3.rsp_ready = 0; bus3.alu_result = 0;

      // Reset state
      #12;
      chk("rst_rsp_valid", 64'(bus1.rsp_valid), 64'd0);
      chk("rst_alu_op", 64'(bus1.alu_op), 64'd0);
      chk("rst_alu_start", 64'(bus1.alu_start), 64'd0);
      chk("rst_rsp_result", 64'(bus1.rsp_result), 64'd0);
      rst_n = 1'b1;
      tick();

      // Round-robin: both valid continuously, rsp_ready tied high
      bus1.req0_aluop = 3'b010; bus1.req0_func = 5'b00010; bus1.req0_a = 32'd10;  bus1.req0_b = 32'd20;
      bus1.req1_aluop = 3'b011; bus1.req1_func = 5'b00100; bus1.req1_a = 32'd100; bus1.req1_b = 32'd1;
      bus1.req0_valid = 1; bus1.req1_valid = 1; bus1.rsp_ready = 1;
      for (int k = 0; k < 12; k++) begin
         logic acc;
         logic eid;
         #1;
         acc = (k % 3 == 0);
         eid = ((k / 3) % 2 == 1);
         chk("rr_ready0", 64'(bus1.req0_ready), 64'(acc && !eid));
         chk("rr_ready1", 64'(bus1.req1_ready), 64'(acc && eid));
         chk("rr_excl", 64'(bus1.req0_ready && bus1.req1_ready), 64'd0);
         chk("rr_start", 64'(bus1.alu_start), 64'(k % 3 == 1));
         if (acc) sb.push_back(eid ? {1'b1, 32'd101} : {1'b0, 32'd30});
         tick();
      end
      bus1.req0_valid = 0; bus1.req1_valid = 0; bus1.rsp_ready = 0;

      // Single op, latency 1: 5 + 3
      bus1.req0_aluop = 3'b001; bus1.req0_func = 5'b00001; bus1.req0_a = 32'd5; bus1.req0_b = 32'd3;
      bus1.req0_valid = 1;
      #1;
      chk("t1_ready0", 64'(bus1.req0_ready), 64'd1);
      chk("t1_ready1", 64'(bus1.req1_ready), 64'd0);
      sb.push_back({1'b0, 32'd8});
      tick();
      bus1.req0_valid = 0;
      #1;
      chk("t1_start", 64'(bus1.alu_start), 64'd1);
      chk("t1_op", 64'(bus1.alu_op), 64'd1);
      chk("t1_func", 64'(bus1.alu_func), 64'd1);
      chk("t1_a", 64'(bus1.alu_a), 64'd5);
      chk("t1_rsp_early", 64'(bus1.rsp_valid), 64'd0);
      tick();
      chk("t1_start_off", 64'(bus1.alu_start), 64'd0);
      chk("t1_rsp_valid", 64'(bus1.rsp_valid), 64'd1);
      chk("t1_rsp_result", 64'(bus1.rsp_result), 64'd8);
      chk("t1_rsp_id", 64'(bus1.rsp_id), 64'd0);
      chk("t1_op_nop", 64'(bus1.alu_op), 64'd0);
      bus1.rsp_ready = 1;
      tick();
      chk("t1_rsp_drop", 64'(bus1.rsp_valid), 64'd0);
      bus1.rsp_ready = 0;

      // Backpressure with req0 held valid throughout: 7 + 9
      bus1.req0_aluop = 3'b100; bus1.req0_func = 5'b01000; bus1.req0_a = 32'd7; bus1.req0_b = 32'd9;
      bus1.req0_valid = 1;
      #1;
      chk("bp_ready0", 64'(bus1.req0_ready), 64'd1);
      sb.push_back({1'b0, 32'd16});
      tick();
      chk("bp_exec_op", 64'(bus1.alu_op), 64'd4);
      tick();
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_rsp_valid", 64'(bus1.rsp_valid), 64'd1);
         chk("bp_rsp_id", 64'(bus1.rsp_id), 64'd0);
         chk("bp_rsp_result", 64'(bus1.rsp_result), 64'd16);
         chk("bp_ready0", 64'(bus1.req0_ready), 64'd0);
         chk("bp_alu_op", 64'(bus1.alu_op), 64'd0);
         tick();
      end
      bus1.rsp_ready = 1;
      #1;
      chk("bp_rsp_hold", 64'(bus1.rsp_valid), 64'd1);
      tick();
      chk("bp_idle_rsp", 64'(bus1.rsp_valid), 64'd0);
      chk("bp_reaccept", 64'(bus1.req0_ready), 64'd1);
      sb.push_back({1'b0, 32'd16});
      tick();
      bus1.req0_valid = 0;
      tick();
      tick();

      // Withdrawal: req1 pulses during an EXEC of req0
      bus1.req0_aluop = 3'b001; bus1.req0_func = 5'b00001; bus1.req0_a = 32'd1; bus1.req0_b = 32'd2;
      bus1.req0_valid = 1;
      #1;
      chk("wd_ready0", 64'(bus1.req0_ready), 64'd1);
      sb.push_back({1'b0, 32'd3});
      tick();
      bus1.req0_valid = 0;
      bus1.req1_aluop = 3'b101; bus1.req1_func = 5'b10000; bus1.req1_a = 32'd6; bus1.req1_b = 32'd1;
      bus1.req1_valid = 1;
      #1;
      chk("wd_ready1_exec", 64'(bus1.req1_ready), 64'd0);
      tick();
      bus1.req1_valid = 0;
      #1;
      chk("wd_ready1_resp", 64'(bus1.req1_ready), 64'd0);
      tick();
      bus1.req0_a = 32'd2; bus1.req0_b = 32'd2;
      bus1.req0_valid = 1; bus1.req1_valid = 1;
      #1;
      chk("wd_tie_ready1", 64'(bus1.req1_ready), 64'd1);
      chk("wd_tie_ready0", 64'(bus1.req0_ready), 64'd0);
      sb.push_back({1'b1, 32'd7});
      tick();
      bus1.req0_valid = 0; bus1.req1_valid = 0;
      #1;
      chk("wd_exec_a", 64'(bus1.alu_a), 64'd6);
      tick();
      tick();
      bus1.rsp_ready = 0;

      // Latency 3 on the second instance
      bus3.req1_aluop = 3'b011; bus3.req1_func = 5'b00100; bus3.req1_a = 32'h55; bus3.req1_b = 32'hAA;
      bus3.req1_valid = 1;
      #1;
      chk("l3_ready1", 64'(bus3.req1_ready), 64'd1);
      tick();
      bus3.req1_valid = 0;
      for (int k = 0; k < 3; k++) begin
         bus3.alu_result = 32'h111 * 32'(k + 1);
         #1;
         chk("l3_start", 64'(bus3.alu_start), 64'(k == 0));
         chk("l3_op", 64'(bus3.alu_op), 64'd3);
         chk("l3_func", 64'(bus3.alu_func), 64'd4);
         chk("l3_a", 64'(bus3.alu_a), 64'h55);
         chk("l3_b", 64'(bus3.alu_b), 64'hAA);
         chk("l3_rsp_early", 64'(bus3.rsp_valid), 64'd0);
         tick();
      end
      bus3.alu_result = 32'hDEAD;
      #1;
      chk("l3_rsp_valid", 64'(bus3.rsp_valid), 64'd1);
      chk("l3_rsp_result", 64'(bus3.rsp_result), 64'h333);
      chk("l3_rsp_id", 64'(bus3.rsp_id), 64'd1);
      chk("l3_op_nop", 64'(bus3.alu_op), 64'd0);
      bus3.rsp_ready = 1;
      tick();
      chk("l3_rsp_drop", 64'(bus3.rsp_valid), 64'd0);
      bus3.rsp_ready = 0;

      // Reset in the middle of an EXEC; the abandoned op must never respond
      bus1.req0_aluop = 3'b110; bus1.req0_func = 5'b00010; bus1.req0_a = 32'd9; bus1.req0_b = 32'd9;
      bus1.req0_valid = 1;
      tick();
      bus1.req0_valid = 0;
      #1;
      chk("rm_pre_start", 64'(bus1.alu_start), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rm_start", 64'(bus1.alu_start), 64'd0);
      chk("rm_op", 64'(bus1.alu_op), 64'd0);
      chk("rm_func", 64'(bus1.alu_func), 64'd0);
      chk("rm_rsp_valid", 64'(bus1.rsp_valid), 64'd0);
      tick();
      tick();
      #2;
      rst_n = 1'b1;
      bus1.rsp_ready = 1;
      tick();
      chk("rm_no_stale", 64'(bus1.rsp_valid), 64'd0);
      bus1.req0_a = 32'd4; bus1.req0_b = 32'd4;
      bus1.req1_a = 32'd8; bus1.req1_b = 32'd8;
      bus1.req0_valid = 1; bus1.req1_valid = 1;
      #1;
      chk("rm_tie_ready0", 64'(bus1.req0_ready), 64'd1);
      chk("rm_tie_ready1", 64'(bus1.req1_ready), 64'd0);
      sb.push_back({1'b0, 32'd8});
      tick();
      bus1.req0_valid = 0; bus1.req1_valid = 0;
      tick();
      tick();
      tick();
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares the single execute-stage ALU, with its 3-bit ALUop and 5-bit function-code control, between two requesters.
  - Requester 0: main integer pipeline.
  - Requester 1: address/branch-target helper.
- Arbitrates round-robin and registers the winner's operation.
- Drives the ALU for a fixed latency, captures the result and returns it on a shared response channel tagged with the requester id.
- Executes one operation at a time; no overlap between response and the next issue.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- ALU_LATENCY, 1, cycles from alu_start to a valid alu_result. Legal range 1..15; 0 is illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid is also high.
- req0_aluop / req1_aluop  in  3  ALUop field.
- req0_func / req1_func  in  5  function code (one-hot per ALUop group).
- req0_a, req0_b / req1_a, req1_b  in  DATA_WIDTH  operands.
- alu_start  out  1  one-cycle pulse at the first cycle of execution.
- alu_op  out  3  ALUop to the ALU/ALU control.
- alu_func  out  5  function code to the ALU control.
- alu_a, alu_b  out  DATA_WIDTH  operands to the ALU.
- alu_result  in  DATA_WIDTH  ALU output.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  DATA_WIDTH  captured result.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - All outputs go to 0, including alu_op=000 (NOP) and alu_func=00000.
  - Latency counter goes to 0.
  - Last-grant pointer goes to 1, so requester 0 wins the first tie.
  - Reset mid-operation abandons the operation; no response is produced.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Winner is the only valid requester; if both are valid, the one not granted last.
  - Only the winner's ready is high (combinational from valid and the pointer); the other ready is 0. No ready is asserted if no requester is valid.
  - On valid&ready: latch aluop/func/a/b into the issue registers, latch id, update the pointer to the id, load counter = ALU_LATENCY, go to EXEC.
  - The pointer changes only on an accept.
- EXEC:
  - alu_op/alu_func/alu_a/alu_b are driven from the issue registers and held stable for all ALU_LATENCY cycles.
  - alu_start is 1 in the first EXEC cycle only.
  - Counter decrements each cycle. When counter==1, alu_result is captured into rsp_result at that edge and the state goes to RESP.
  - Both ready outputs are 0.
- RESP:
  - rsp_valid=1; rsp_id and rsp_result are held stable until rsp_ready.
  - alu_op/alu_func return to 0; both ready outputs are 0.
  - On rsp_ready: rsp_valid drops at the next edge and the state goes to IDLE.
  - rsp_ready high in the first RESP cycle gives a single-cycle RESP.
- Timing:
  - Accept edge to rsp_valid high: ALU_LATENCY+1 edges.
  - Minimum issue interval: ALU_LATENCY+2 cycles.
- Fields are forwarded unchanged. No legality check of the ALUop/function-code pair; undefined pairs are resolved downstream to control 00000.
- Requester rules:
  - A requester must hold valid and its fields stable until accepted.
  - Dropping valid before accept is allowed: that request is never issued and the pointer is unchanged.
- rsp_ready asserted while rsp_valid=0 is ignored.

Test Plan:
1. Single op, ALU_LATENCY=1: req0 ALUop=001, func=00001, a=5, b=3; ALU model adds.
   - Required: alu_start pulses 1 edge after accept, with alu_op=001 and alu_func=00001.
   - Required: rsp_valid rises 2 edges after accept with rsp_result=8, rsp_id=0.
2. Round-robin: both requesters hold valid continuously for 4 ops, rsp_ready tied 1.
   - Required: grant order 0,1,0,1; issues spaced 3 cycles apart.
   - Required: req1_ready never high while req0_ready is high.
3. Latency: ALU_LATENCY=3, req1 ALUop=011, func=00100.
   - Required: alu_op/alu_func/alu_a/alu_b stable for 3 cycles; alu_start high exactly 1 cycle.
   - Required: rsp_valid 4 edges after accept; rsp_result equals alu_result sampled in the 3rd EXEC cycle.
4. Backpressure: hold rsp_ready=0 for 5 cycles in RESP, with req0_valid high throughout.
   - Required: rsp_valid, rsp_id and rsp_result unchanged; req0_ready=0 and alu_op=000 throughout.
   - Required: after rsp_ready=1, IDLE at the next edge and req0 accepted in that IDLE cycle.
5. Withdrawal: req1_valid pulses 1 cycle during an EXEC of req0.
   - Required: req1 is never granted; the pointer stays 0, so a later tie grants req1.
6. Reset mid-EXEC: rst_n low asynchronously between edges.
   - Required: alu_start, alu_op, alu_func and rsp_valid drop to 0 without a clock edge.
   - Required: after release, a tie grants req0 first and no stale response appears.
